// File: rtl/comp_sweep_driver.sv
// Sweeps a 2-bit comparator through all 16 a/b combinations and logs its
// red/green/blue response per combination into a readable 16-entry table.
module comp_sweep_driver #(
  parameter int TICK_DIV = 8,
  parameter int SETTLE   = 2,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] a,
  output logic [1:0] b,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data
);

  if (TICK_DIV < SETTLE + 2) begin : g_bad_tick_div
    $error("TICK_DIV must be at least SETTLE+2");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end

  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       index;
  logic [CNT_W-1:0] step;
  logic [2:0]       log_mem [16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      index        <= 4'd0;
      step         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_valid <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        log_mem[i] <= 3'b000;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // start outranks abort here; abort only matters while running
          if (start) begin
            state <= RUN;
            index <= 4'd0;
            step  <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            index <= 4'd0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            if (step == SETTLE_CNT) begin
              log_mem[index] <= {red, green, blue};
              sample_valid   <= 1'b1;
            end
            if (step == LAST_CNT) begin
              step <= '0;
              // the final combination stays on a/b while DONE
              if (index == 4'hF) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                index <= index + 4'd1;
              end
            end else begin
              step <= step + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= 4'd0;
          step  <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign a       = index[3:2];
  assign b       = index[1:0];
  assign rd_data = log_mem[rd_addr];

endmodule

// File: tb/tb_comp_sweep_driver.sv
// Randomized bench for comp_sweep_driver with a cycle-indexed reference model.
module tb_comp_sweep_driver;
  localparam int TICK_DIV = 8;
  localparam int SETTLE   = 2;
  localparam int SWEEP    = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       red, green, blue;
  logic [1:0] a, b;
  logic       busy, done, sample_valid;
  logic [3:0] rd_addr;
  logic [2:0] rd_data;

  int checks = 0;
  int passes = 0;
  int mode   = 0;  // 0: comparator, 1: glitch 111 except at settle, 2: random table
  int k      = 0;  // cycle number within the current sweep
  logic [2:0] rnd     [16];
  logic [2:0] exp_log [16];
  logic [2:0] rgb;

  always #5 clk = ~clk;

  comp_sweep_driver #(.TICK_DIV(TICK_DIV), .SETTLE(SETTLE), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .red(red), .green(green), .blue(blue),
    .busy(busy), .done(done), .sample_valid(sample_valid),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  function automatic logic [2:0] cmp(input logic [3:0] x);
    logic [1:0] xa, xb;
    xa = x[3:2];
    xb = x[1:0];
    return {xa > xb, xa == xb, xa < xb};
  endfunction

  always_comb begin
    rgb = cmp({a, b});
    if (mode == 1)
      rgb = (k % TICK_DIV == SETTLE) ? cmp(4'(k / TICK_DIV)) : 3'b111;
    else if (mode == 2)
      rgb = (k % TICK_DIV == SETTLE) ? rnd[4'(k / TICK_DIV)] : ~rnd[4'(k / TICK_DIV)];
  end
  assign {red, green, blue} = rgb;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int abort_k, input int extra1, input int extra2,
                           input int reset_k, input bit with_abort, output int svc);
    logic [6:0] expv;
    int idx;
    svc = 0;
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    k = 0;
    checks++;
    if ({a, b, busy, done, sample_valid} !== 7'b0000_100)
      $display("FAIL sweep_start: got %b want %b", {a, b, busy, done, sample_valid}, 7'b0000_100);
    else passes++;
    for (int n = 0; n < SWEEP; n++) begin
      idx = n / TICK_DIV;
      if (n == reset_k) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, busy, done, sample_valid} !== 7'b0)
          $display("FAIL reset_mid_run: got %b want %b", {a, b, busy, done, sample_valid}, 7'b0);
        else passes++;
        for (int i = 0; i < 16; i++) exp_log[i] = 3'b000;
        return;
      end
      start = (n == extra1 || n == extra2);
      abort = (n == abort_k);
      if (n % TICK_DIV == SETTLE && n != abort_k) begin
        if (idx == 5) begin
          rd_addr = 4'(idx);
          #1;
          checks++;
          if (rd_data !== exp_log[idx])
            $display("FAIL read_old_same_cycle: got %b want %b", rd_data, exp_log[idx]);
          else passes++;
        end
        exp_log[idx] = (mode == 2) ? rnd[idx] : cmp(4'(idx));
      end
      tick();
      k = n + 1;
      start = 1'b0;
      abort = 1'b0;
      if (n == abort_k) begin
        checks++;
        if ({a, b, busy, done, sample_valid} !== 7'b0)
          $display("FAIL abort_outputs: got %b want %b", {a, b, busy, done, sample_valid}, 7'b0);
        else passes++;
        return;
      end
      if (n + 1 == SWEEP)
        expv = {4'hF, 1'b0, 1'b1, 1'(n % TICK_DIV == SETTLE)};
      else
        expv = {4'((n + 1) / TICK_DIV), 1'b1, 1'b0, 1'(n % TICK_DIV == SETTLE)};
      checks++;
      if ({a, b, busy, done, sample_valid} !== expv)
        $display("FAIL sweep_cycle_%0d: got %b want %b", n + 1, {a, b, busy, done, sample_valid}, expv);
      else passes++;
      if (sample_valid) svc++;
      if (idx == 5 && n % TICK_DIV == SETTLE) begin
        checks++;
        if (rd_data !== exp_log[idx])
          $display("FAIL read_new_next_cycle: got %b want %b", rd_data, exp_log[idx]);
        else passes++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_addr = 4'd0;
    for (int i = 0; i < 16; i++) exp_log[i] = 3'b000;
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if ({a, b, busy, done, sample_valid} !== 7'b0)
      $display("FAIL reset_state: got %b want %b", {a, b, busy, done, sample_valid}, 7'b0);
    else passes++;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, busy, done, sample_valid} !== 7'b0)
      $display("FAIL reset_async: got %b want %b", {a, b, busy, done, sample_valid}, 7'b0);
    else passes++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== 3'b000) $display("FAIL reset_log_%0d: got %b want 000", i, rd_data);
      else passes++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_sweep;
    int svc;
    logic [2:0] spec_val [4];
    logic [3:0] spec_adr [4];
    spec_adr[0] = 4'b0000; spec_val[0] = 3'b010;
    spec_adr[1] = 4'b0100; spec_val[1] = 3'b100;
    spec_adr[2] = 4'b0011; spec_val[2] = 3'b001;
    spec_adr[3] = 4'b1111; spec_val[3] = 3'b010;
    mode = 0;
    run_sweep(-1, -1, -1, -1, 1'b0, svc);
    checks++;
    if (svc !== 16) $display("FAIL sample_pulses: got %0d want 16", svc);
    else passes++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== exp_log[i]) $display("FAIL full_log_%0d: got %b want %b", i, rd_data, exp_log[i]);
      else passes++;
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = spec_adr[i];
      #1;
      checks++;
      if (rd_data !== spec_val[i]) $display("FAIL readback_%b: got %b want %b", spec_adr[i], rd_data, spec_val[i]);
      else passes++;
    end
  endtask

  task automatic test_abort_in_done;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({a, b, busy, done, sample_valid} !== 7'b1111_010)
        $display("FAIL abort_in_done: got %b want %b", {a, b, busy, done, sample_valid}, 7'b1111_010);
      else passes++;
      tick();
    end
  endtask

  task automatic test_random;
    int svc;
    for (int i = 0; i < 16; i++) rnd[i] = 3'($urandom);
    rnd[6] = ~cmp(4'd6);
    mode = 2;
    run_sweep(-1, -1, -1, -1, 1'b0, svc);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== exp_log[i]) $display("FAIL random_log_%0d: got %b want %b", i, rd_data, exp_log[i]);
      else passes++;
    end
  endtask

  task automatic test_abort;
    int svc;
    mode = 0;
    run_sweep(6 * TICK_DIV + 1, -1, -1, -1, 1'b0, svc);
    tick();
    checks++;
    if ({a, b, busy, done} !== 6'b0) $display("FAIL abort_stays_idle: got %b want 000000", {a, b, busy, done});
    else passes++;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== exp_log[i]) $display("FAIL abort_log_%0d: got %b want %b", i, rd_data, exp_log[i]);
      else passes++;
    end
  endtask

  task automatic test_settle;
    int svc;
    mode = 1;
    run_sweep(-1, -1, -1, -1, 1'b0, svc);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== cmp(4'(i))) $display("FAIL settle_log_%0d: got %b want %b", i, rd_data, cmp(4'(i)));
      else passes++;
    end
  endtask

  task automatic test_back_to_back;
    int svc;
    mode = 0;
    run_sweep(-1, 3 * TICK_DIV, 10 * TICK_DIV, -1, 1'b0, svc);
    checks++;
    if (svc !== 16) $display("FAIL b2b_sample_pulses: got %0d want 16", svc);
    else passes++;
  endtask

  task automatic test_restart_reset;
    int svc;
    for (int i = 0; i < 16; i++) rnd[i] = 3'($urandom);
    mode = 2;
    run_sweep(-1, -1, -1, 9 * TICK_DIV + 3, 1'b1, svc);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      checks++;
      if (rd_data !== exp_log[i]) $display("FAIL reset_clear_%0d: got %b want %b", i, rd_data, exp_log[i]);
      else passes++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++;
    if ({a, b, busy, done, sample_valid} !== 7'b0)
      $display("FAIL post_reset_idle: got %b want %b", {a, b, busy, done, sample_valid}, 7'b0);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_sweep();
    test_abort_in_done();
    test_random();
    test_abort();
    test_settle();
    test_back_to_back();
    test_restart_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
